spike_synapse_decoder: RTL and testbench
========================================

SPIKE_SYNAPSE_DECODER -- requirements
Module: spike_synapse_decoder

Interface
REQ-001 Parameter DECAY_SHIFT, default 3: right-shift amount of the synaptic current leak.
REQ-002 Parameter WINDOW, default 256: rate-measurement window length in clock cycles (2..65536).
REQ-003 Block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 spike_in  input  1  spike line from an upstream EIF neuron; level, one or more cycles per spike.
REQ-007 weight  input  8  unsigned synaptic weight, sampled only when weight_wr=1.
REQ-008 weight_wr  input  1  loads weight into internal weight register.
REQ-009 current_out  output  8  synaptic current; drives a downstream neuron current input.
REQ-010 rate_out  output  8  spikes counted in the last completed window, saturating.
REQ-011 rate_valid  output  1  rate_out holds an unconsumed window result.
REQ-012 rate_ready  input  1  consumer accepts rate_out.
REQ-013 isi_out  output  8  cycles between the last two spike events, saturating.
REQ-014 overrun  output  1  sticky; a window result was dropped.

Function
REQ-015 Event = spike_in rising edge (spike_in=1, registered previous value=0); a level held high SHALL count as one event.
REQ-016 Weight register SHALL update one cycle after weight_wr=1; an event in the same cycle SHALL use the old weight.
REQ-017 Current update per cycle, 9-bit intermediate: next = I - (I >> DECAY_SHIFT) + (event ? weight : 0), clamped to 255.
REQ-018 If I>0 and (I >> DECAY_SHIFT)=0, the leak term SHALL be 1, so current always decays to 0.
REQ-019 current_out SHALL reflect an event on the rising edge following the event cycle (latency 1).
REQ-020 Window counter SHALL count 0..WINDOW-1 and wrap to 0; terminal count = WINDOW-1.
REQ-021 Spike counter SHALL increment per event, saturate at 255, and clear at terminal count.
REQ-022 An event coinciding with terminal count SHALL be included in the ending window; the new window starts at 0.
REQ-023 Output FSM states: IDLE (rate_valid=0), VALID (rate_valid=1).
REQ-024 IDLE -> VALID at terminal count; rate_out loaded with the final window count.
REQ-025 VALID -> IDLE on rate_valid & rate_ready; rate_out held stable while in VALID.
REQ-026 Terminal count while VALID and rate_ready=0: new result dropped, overrun set, rate_out unchanged.
REQ-027 Terminal count while VALID and rate_ready=1 in the same cycle: accept old result, load new, stay VALID, no overrun.
REQ-028 ISI counter SHALL increment every cycle, saturating at 255; on event, isi_out <= ISI counter value and counter <= 1.
REQ-029 First event after reset SHALL report cycles since reset release (saturating) on isi_out.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 While rst=1: current_out=0, rate_out=0, rate_valid=0, isi_out=0, overrun=0, weight register=0, window, spike and ISI counters=0, previous spike_in=0, FSM=IDLE.
REQ-032 Reset asserted mid-window SHALL discard the partial count; the first window after release is a full WINDOW cycles.
REQ-033 spike_in high in the first cycle after reset release SHALL count as an event.

Verification
REQ-034 weight=64 loaded, single 1-cycle spike -> current_out 64, 56, 49, 43 on successive cycles, then monotonic decay to 0.
REQ-035 weight=200, spikes 2 cycles apart -> current_out 200, then clamps at 255; never wraps.
REQ-036 WINDOW=256, 10 spikes in the window, rate_ready=1 -> rate_valid pulses 1 cycle after terminal count with rate_out=10.
REQ-037 rate_ready=0 across two terminal counts -> rate_out keeps the first count, overrun=1, rate_valid stays 1.
REQ-038 Spikes at cycles 5 and 25, then spike_in held high 10 cycles -> isi_out=20, one event counted; 300-cycle gap -> isi_out=255.
REQ-039 rst pulsed mid-window with current_out=120 -> all outputs 0 next cycle; next rate_out counts only post-reset spikes.

Source files
------------

// File: rtl/spike_synapse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spike_synapse_decoder
// Function : spike edge detect, leaky synaptic current, windowed rate, ISI
// Revision : 1.0
// ============================================================================
module spike_synapse_decoder #(
    parameter int DECAY_SHIFT = 3,
    parameter int WINDOW      = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic [7:0] weight,
    input  logic       weight_wr,
    output logic [7:0] current_out,
    output logic [7:0] rate_out,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic [7:0] isi_out,
    output logic       overrun
);

    localparam int                 c_WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [c_WIN_W-1:0] c_TC    = c_WIN_W'(WINDOW - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t             state_q;
    logic               spike_prev_q;
    logic [7:0]         weight_q;
    logic [7:0]         cur_q,  cur_d;
    logic [c_WIN_W-1:0] win_q,  win_d;
    logic [7:0]         spk_q,  spk_d;
    logic [7:0]         isi_cnt_q, isi_cnt_d;
    logic [7:0]         isi_q;
    logic [7:0]         rate_q;
    logic               valid_q;
    logic               ovr_q;

    logic               w_event;
    logic               w_tc;
    logic [7:0]         w_shift;
    logic [7:0]         w_leak;
    logic [8:0]         w_sum;
    logic [7:0]         w_spk_final;

    assign w_event = spike_in & ~spike_prev_q;
    assign w_tc    = (win_q == c_TC);

    always_comb begin
        // A non-zero current always leaks at least 1 so it reaches zero.
        w_shift = cur_q >> DECAY_SHIFT;
        w_leak  = ((cur_q != 8'd0) && (w_shift == 8'd0)) ? 8'd1 : w_shift;
        w_sum   = {1'b0, cur_q} - {1'b0, w_leak} + (w_event ? {1'b0, weight_q} : 9'd0);
        cur_d   = w_sum[8] ? 8'hFF : w_sum[7:0];

        w_spk_final = (spk_q == 8'hFF) ? spk_q : spk_q + {7'd0, w_event};
        spk_d       = w_tc ? 8'd0 : w_spk_final;
        win_d       = w_tc ? '0 : win_q + c_WIN_W'(1);

        if (w_event) begin
            isi_cnt_d = 8'd1;
        end else begin
            isi_cnt_d = (isi_cnt_q == 8'hFF) ? isi_cnt_q : isi_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_prev_q <= 1'b0;
            weight_q     <= 8'd0;
            cur_q        <= 8'd0;
            win_q        <= '0;
            spk_q        <= 8'd0;
            isi_cnt_q    <= 8'd0;
            isi_q        <= 8'd0;
        end else begin
            spike_prev_q <= spike_in;
            if (weight_wr) begin
                weight_q <= weight;
            end
            cur_q     <= cur_d;
            win_q     <= win_d;
            spk_q     <= spk_d;
            isi_cnt_q <= isi_cnt_d;
            if (w_event) begin
                isi_q <= isi_cnt_q;
            end
        end
    end

    // Result handshake: a terminal count while a result is still pending
    // replaces it only if the consumer takes the old one in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            rate_q  <= 8'd0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_tc) begin
                        state_q <= ST_VALID;
                        valid_q <= 1'b1;
                        rate_q  <= w_spk_final;
                    end
                end
                ST_VALID: begin
                    if (w_tc) begin
                        if (rate_ready) begin
                            rate_q <= w_spk_final;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else if (rate_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign current_out = cur_q;
    assign rate_out    = rate_q;
    assign rate_valid  = valid_q;
    assign isi_out     = isi_q;
    assign overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_synapse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spike_synapse_decoder
// Function : directed self-checking bench for spike_synapse_decoder
// Revision : 1.0
// ============================================================================
module tb_spike_synapse_decoder;

    logic       clk;
    logic       rst;
    logic       spike_in;
    logic [7:0] weight;
    logic       weight_wr;
    logic [7:0] current_out;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic       rate_ready;
    logic [7:0] isi_out;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit early_valid;

    spike_synapse_decoder #(
        .DECAY_SHIFT(3),
        .WINDOW     (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .weight     (weight),
        .weight_wr  (weight_wr),
        .current_out(current_out),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .isi_out    (isi_out),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after a reset edge; the next edge is edge 0.
    task automatic do_reset();
        rst        = 1'b1;
        spike_in   = 1'b0;
        weight     = 8'd0;
        weight_wr  = 1'b0;
        rate_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // One full window of 256 edges; one-cycle spikes at offsets 20,30,...
    task automatic run_window(input int nspk, input bit last_spk,
                              input bit rdy_body, input bit rdy_tc);
        early_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            spike_in   = ((k >= 20) && (k < 20 + 10 * nspk) && (k % 10 == 0)) ||
                         (last_spk && (k == 255));
            rate_ready = (k == 255) ? rdy_tc : rdy_body;
            tick();
            if (k < 255 && rate_valid) early_valid = 1'b1;
        end
        spike_in   = 1'b0;
        rate_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spike_in = 1'b1; weight = 8'd99; weight_wr = 1'b1; rate_ready = 1'b1;
        repeat (3) tick();
        n_tests++; if (current_out !== 8'd0) begin n_fail++; $display("FAIL rst_current got %0d expected 0", current_out); end
        n_tests++; if (rate_out !== 8'd0) begin n_fail++; $display("FAIL rst_rate got %0d expected 0", rate_out); end
        n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b expected 0", rate_valid); end
        n_tests++; if (isi_out !== 8'd0) begin n_fail++; $display("FAIL rst_isi got %0d expected 0", isi_out); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %0b expected 0", overrun); end
        spike_in = 1'b0; weight_wr = 1'b0; rate_ready = 1'b0;
    endtask

    task automatic test_decay();
        logic [7:0] prev;
        bit         mono_ok;
        bit         reached;
        do_reset();
        weight = 8'd64; weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0; spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd64) begin n_fail++; $display("FAIL decay_0 got %0d expected 64", current_out); end
        n_tests++; if (isi_out !== 8'd1) begin n_fail++; $display("FAIL isi_first got %0d expected 1", isi_out); end
        spike_in = 1'b0;
        tick();
        n_tests++; if (current_out !== 8'd56) begin n_fail++; $display("FAIL decay_1 got %0d expected 56", current_out); end
        tick();
        n_tests++; if (current_out !== 8'd49) begin n_fail++; $display("FAIL decay_2 got %0d expected 49", current_out); end
        tick();
        n_tests++; if (current_out !== 8'd43) begin n_fail++; $display("FAIL decay_3 got %0d expected 43", current_out); end
        prev = current_out; mono_ok = 1'b1; reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (current_out >= prev) mono_ok = 1'b0;
            prev = current_out;
            if (current_out == 8'd0) begin
                reached = 1'b1;
                break;
            end
        end
        n_tests++; if (mono_ok !== 1'b1) begin n_fail++; $display("FAIL decay_monotonic got %0b expected 1", mono_ok); end
        n_tests++; if (reached !== 1'b1) begin n_fail++; $display("FAIL decay_to_zero got %0d expected 0", current_out); end
        weight = 8'd10; weight_wr = 1'b1; spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd64) begin n_fail++; $display("FAIL weight_old got %0d expected 64", current_out); end
        weight_wr = 1'b0; spike_in = 1'b0;
        tick();
        spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd59) begin n_fail++; $display("FAIL weight_new got %0d expected 59", current_out); end
        spike_in = 1'b0;
    endtask

    task automatic test_clamp();
        do_reset();
        weight = 8'd200; weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0; spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd200) begin n_fail++; $display("FAIL clamp_0 got %0d expected 200", current_out); end
        spike_in = 1'b0;
        tick();
        n_tests++; if (current_out !== 8'd175) begin n_fail++; $display("FAIL clamp_1 got %0d expected 175", current_out); end
        spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd255) begin n_fail++; $display("FAIL clamp_2 got %0d expected 255", current_out); end
        spike_in = 1'b0;
        tick();
        n_tests++; if (current_out !== 8'd224) begin n_fail++; $display("FAIL clamp_3 got %0d expected 224", current_out); end
        spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd255) begin n_fail++; $display("FAIL clamp_4 got %0d expected 255", current_out); end
        spike_in = 1'b0;
    endtask

    task automatic test_rate();
        do_reset();
        run_window(9, 1'b1, 1'b1, 1'b1);
        n_tests++; if (early_valid !== 1'b0) begin n_fail++; $display("FAIL rate_early got %0b expected 0", early_valid); end
        n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL rate_valid got %0b expected 1", rate_valid); end
        n_tests++; if (rate_out !== 8'd10) begin n_fail++; $display("FAIL rate_count got %0d expected 10", rate_out); end
        rate_ready = 1'b1;
        tick();
        n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL rate_pulse got %0b expected 0", rate_valid); end
        rate_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_window(3, 1'b0, 1'b0, 1'b0);
        n_tests++; if (rate_out !== 8'd3) begin n_fail++; $display("FAIL b2b_w1_rate got %0d expected 3", rate_out); end
        run_window(4, 1'b0, 1'b0, 1'b1);
        n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_w2_valid got %0b expected 1", rate_valid); end
        n_tests++; if (rate_out !== 8'd4) begin n_fail++; $display("FAIL b2b_w2_rate got %0d expected 4", rate_out); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_w2_overrun got %0b expected 0", overrun); end
        run_window(5, 1'b0, 1'b0, 1'b0);
        n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %0b expected 1", rate_valid); end
        n_tests++; if (rate_out !== 8'd4) begin n_fail++; $display("FAIL ovr_rate_held got %0d expected 4", rate_out); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b expected 1", overrun); end
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept got %0b expected 0", rate_valid); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %0b expected 1", overrun); end
    endtask

    task automatic test_isi();
        do_reset();
        for (int k = 0; k <= 360; k++) begin
            spike_in   = (k == 5) || (k == 25) || ((k >= 45) && (k <= 54)) || (k == 60) || (k == 360);
            rate_ready = 1'b1;
            tick();
            if (k == 5) begin
                n_tests++; if (isi_out !== 8'd5) begin n_fail++; $display("FAIL isi_5 got %0d expected 5", isi_out); end
            end
            if (k == 25) begin
                n_tests++; if (isi_out !== 8'd20) begin n_fail++; $display("FAIL isi_20 got %0d expected 20", isi_out); end
            end
            if (k == 52) begin
                n_tests++; if (isi_out !== 8'd20) begin n_fail++; $display("FAIL isi_hold got %0d expected 20", isi_out); end
            end
            if (k == 60) begin
                n_tests++; if (isi_out !== 8'd15) begin n_fail++; $display("FAIL isi_after_hold got %0d expected 15", isi_out); end
            end
            if (k == 255) begin
                n_tests++; if (rate_out !== 8'd4) begin n_fail++; $display("FAIL isi_one_event got %0d expected 4", rate_out); end
            end
            if (k == 360) begin
                n_tests++; if (isi_out !== 8'd255) begin n_fail++; $display("FAIL isi_sat got %0d expected 255", isi_out); end
            end
        end
        spike_in = 1'b0; rate_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        weight = 8'd120; weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            spike_in = (k == 20);
            tick();
        end
        n_tests++; if (current_out !== 8'd120) begin n_fail++; $display("FAIL mid_pre got %0d expected 120", current_out); end
        rst = 1'b1; spike_in = 1'b1;
        tick();
        n_tests++; if (current_out !== 8'd0) begin n_fail++; $display("FAIL mid_current got %0d expected 0", current_out); end
        n_tests++; if (isi_out !== 8'd0) begin n_fail++; $display("FAIL mid_isi got %0d expected 0", isi_out); end
        n_tests++; if ({rate_valid, overrun, rate_out} !== 10'd0) begin n_fail++; $display("FAIL mid_rate got %0h expected 0", {rate_valid, overrun, rate_out}); end
        rst = 1'b0;
        for (int k = 0; k < 256; k++) begin
            spike_in   = (k == 0) || (k == 100) || (k == 200);
            rate_ready = 1'b1;
            tick();
            if (k == 0) begin
                n_tests++; if (current_out !== 8'd0) begin n_fail++; $display("FAIL mid_weight_cleared got %0d expected 0", current_out); end
            end
            if (k == 254) begin
                n_tests++; if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL mid_full_window got %0b expected 0", rate_valid); end
            end
        end
        n_tests++; if (rate_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got %0b expected 1", rate_valid); end
        n_tests++; if (rate_out !== 8'd3) begin n_fail++; $display("FAIL mid_count got %0d expected 3", rate_out); end
        spike_in = 1'b0; rate_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; spike_in = 1'b0; weight = 8'd0; weight_wr = 1'b0; rate_ready = 1'b0;
        test_reset();
        test_decay();
        test_clamp();
        test_rate();
        test_back_to_back();
        test_isi();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
